hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have these ports, each listed as name, direction, width and meaning:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 Decode-stage inputs SHALL be:
- BranchD  in  1  branch in ID.
- RsD  in  5  ID source register.
- RtD  in  5  ID source register.
REQ-003 Execute-stage inputs SHALL be:
- RsE  in  5  EX source register.
- RtE  in  5  EX source/destination register.
- WriteRegE  in  5  EX destination.
- MemtoRegE  in  1  EX is a load.
- RegWriteE  in  1  EX writes the register file.
REQ-004 Memory-stage inputs SHALL be:
- WriteRegM  in  5  MEM destination.
- MemtoRegM  in  1  MEM is a load.
- RegWriteM  in  1  MEM writes the register file.
REQ-005 Writeback-stage inputs SHALL be:
- WriteRegW  in  5  WB destination.
- RegWriteW  in  1  WB writes the register file.
REQ-006 Outputs SHALL be:
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- ForwardAD  out  1  forward ALUOutM to branch comparator A.
- ForwardBD  out  1  forward ALUOutM to branch comparator B.
- FlushE  out  1  clear ID/EX.
- ForwardAE  out  2  EX operand A select.
- ForwardBE  out  2  EX operand B select.
- LoadStallCnt  out  16  load-use stall counter.
- BranchStallCnt  out  16  branch stall counter.
REQ-007 Port order SHALL be clk, reset, then BranchD through ForwardBE in the order above, then the two counters.

Function
REQ-008 ForwardAE SHALL be:
- 2'b10 when RsE!=0, RsE==WriteRegM and RegWriteM;
- else 2'b01 when RsE!=0, RsE==WriteRegW and RegWriteW;
- else 2'b00.
REQ-009 ForwardBE SHALL follow REQ-008 with RtE in place of RsE.
REQ-010 When MEM and WB both match, the MEM match SHALL take priority (2'b10).
REQ-011 Register 0 SHALL never produce a forward, regardless of the write enables.
REQ-012 ForwardAD SHALL be 1 iff RsD!=0, RsD==WriteRegM and RegWriteM.
REQ-013 ForwardBD SHALL be 1 iff RtD!=0, RtD==WriteRegM and RegWriteM.
REQ-014 lwstall SHALL be MemtoRegE AND (RsD==RtE OR RtD==RtE).
REQ-015 branchstall SHALL be BranchD AND ((RegWriteE AND (WriteRegE==RsD OR WriteRegE==RtD)) OR (MemtoRegM AND (WriteRegM==RsD OR WriteRegM==RtD))).
REQ-016 StallF, StallD and FlushE SHALL all equal lwstall OR branchstall.
REQ-017 When lwstall and branchstall are both true, a single stall SHALL result.
REQ-018 All outputs except the counters SHALL be purely combinational, with zero-cycle latency and no dependence on clk or reset.
REQ-019 LoadStallCnt SHALL increment by 1 on each rising edge where lwstall=1.
REQ-020 BranchStallCnt SHALL increment by 1 on each rising edge where branchstall=1.
REQ-021 When lwstall and branchstall are both 1 in a cycle, both counters SHALL increment.
REQ-022 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.

Reset
REQ-023 While reset=1 at a rising edge, both counters SHALL load 0.
REQ-024 Reset SHALL take priority over an increment in the same cycle.
REQ-025 Asserting reset mid-operation SHALL NOT alter any combinational output.

Configuration
REQ-026 With macro HAZARD_BRANCH_RESOLVE_ID_EN defined, REQ-012, REQ-013 and REQ-015 SHALL apply as written.
REQ-027 Without HAZARD_BRANCH_RESOLVE_ID_EN:
- ForwardAD and ForwardBD SHALL be constant 0;
- branchstall SHALL be constant 0;
- BranchStallCnt SHALL remain 0;
- BranchD SHALL be ignored.

Verification
REQ-028 The bench SHALL drive RsE=6, WriteRegM=6, RegWriteM=1 and require ForwardAE=2'b10.
REQ-029 The bench SHALL drive RtE=6, WriteRegW=6, RegWriteW=1 with no MEM match and require ForwardBE=2'b01; repeating with WriteRegW=7 SHALL require ForwardBE=2'b00.
REQ-030 The bench SHALL drive RtE=6, RsD=6, MemtoRegE=1 and require StallF=StallD=FlushE=1; with MemtoRegE=0 it SHALL require all three to be 0.
REQ-031 The bench SHALL drive RsD=5 (then RtD=5), WriteRegM=5, RegWriteM=1 and require ForwardAD=1 (then ForwardBD=1); with RsD=0 and WriteRegM=0 it SHALL require 0.
REQ-032 The bench SHALL build HAZARD_BRANCH_RESOLVE_ID_EN in and drive BranchD=1, RegWriteE=1, WriteRegE=5, RsD=5 for 3 cycles, requiring stall outputs=1 and BranchStallCnt=3; a reset pulse SHALL then return the counter to 0.
REQ-033 The bench SHALL drive RsE=0, WriteRegM=0, RegWriteM=1 and require ForwardAE=2'b00.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX/ID forwarding selects, load-use and branch stalls, saturating stall counters.
// Define HAZARD_BRANCH_RESOLVE_ID_EN to enable ID-stage branch forwarding and branch stalls.
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        BranchD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic        MemtoRegE,
    input  logic        RegWriteE,
    input  logic [4:0]  WriteRegM,
    input  logic        MemtoRegM,
    input  logic        RegWriteM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [15:0] LoadStallCnt,
    output logic [15:0] BranchStallCnt
);

    logic        lwstall;
    logic        branchstall;
    logic [15:0] load_stall_cnt_d;
    logic [15:0] load_stall_cnt_q;
    logic [15:0] branch_stall_cnt_d;
    logic [15:0] branch_stall_cnt_q;

    // MEM result is newer than WB, so it wins when both match.
    function automatic logic [1:0] ex_fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0 && src == WriteRegM && RegWriteM)
            sel = 2'b10;
        else if (src != 5'd0 && src == WriteRegW && RegWriteW)
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        ForwardAE = ex_fwd_sel(RsE);
        ForwardBE = ex_fwd_sel(RtE);
    end

    always_comb begin
        lwstall = MemtoRegE && ((RsD == RtE) || (RtD == RtE));
    end

`ifdef HAZARD_BRANCH_RESOLVE_ID_EN
    always_comb begin
        ForwardAD   = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD   = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
        branchstall = BranchD &&
                      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    end
`else
    logic unused_branch_inputs;

    always_comb begin
        ForwardAD            = 1'b0;
        ForwardBD            = 1'b0;
        branchstall          = 1'b0;
        unused_branch_inputs = ^{BranchD, RegWriteE, WriteRegE, MemtoRegM};
    end
`endif

    always_comb begin
        StallF = lwstall || branchstall;
        StallD = lwstall || branchstall;
        FlushE = lwstall || branchstall;
    end

    always_comb begin
        load_stall_cnt_d   = load_stall_cnt_q;
        branch_stall_cnt_d = branch_stall_cnt_q;
        if (lwstall && load_stall_cnt_q != '1)
            load_stall_cnt_d = load_stall_cnt_q + 16'd1;
        if (branchstall && branch_stall_cnt_q != '1)
            branch_stall_cnt_d = branch_stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_stall_cnt_q   <= '0;
            branch_stall_cnt_q <= '0;
        end else begin
            load_stall_cnt_q   <= load_stall_cnt_d;
            branch_stall_cnt_q <= branch_stall_cnt_d;
        end
    end

    always_comb begin
        LoadStallCnt   = load_stall_cnt_q;
        BranchStallCnt = branch_stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; branch checks follow HAZARD_BRANCH_RESOLVE_ID_EN.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        BranchD;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic        StallF, StallD, ForwardAD, ForwardBD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] LoadStallCnt, BranchStallCnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .BranchD(BranchD), .RsD(RsD), .RtD(RtD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE),
        .RegWriteE(RegWriteE), .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM),
        .RegWriteM(RegWriteM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .LoadStallCnt(LoadStallCnt), .BranchStallCnt(BranchStallCnt)
    );

    task automatic clear_inputs();
        BranchD = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        pulse_reset();
        checks++;
        if (LoadStallCnt !== 16'd0) begin
            failures++; $display("FAIL reset_load_cnt got=%0d exp=0", LoadStallCnt);
        end
        checks++;
        if (BranchStallCnt !== 16'd0) begin
            failures++; $display("FAIL reset_branch_cnt got=%0d exp=0", BranchStallCnt);
        end
        checks++;
        if ({StallF, StallD, FlushE, ForwardAE, ForwardBE} !== 7'b0) begin
            failures++; $display("FAIL reset_idle_outputs got=%b exp=0", {StallF, StallD, FlushE, ForwardAE, ForwardBE});
        end
    endtask

    task automatic test_forward_e();
        clear_inputs();
        RsE = 6; WriteRegM = 6; RegWriteM = 1; #1;
        checks++;
        if (ForwardAE !== 2'b10) begin failures++; $display("FAIL fwdAE_mem got=%b exp=10", ForwardAE); end
        clear_inputs();
        RtE = 6; WriteRegW = 6; RegWriteW = 1; WriteRegM = 9; RegWriteM = 1; #1;
        checks++;
        if (ForwardBE !== 2'b01) begin failures++; $display("FAIL fwdBE_wb got=%b exp=01", ForwardBE); end
        WriteRegW = 7; #1;
        checks++;
        if (ForwardBE !== 2'b00) begin failures++; $display("FAIL fwdBE_nomatch got=%b exp=00", ForwardBE); end
        clear_inputs();
        RsE = 12; RtE = 12; WriteRegM = 12; RegWriteM = 1; WriteRegW = 12; RegWriteW = 1; #1;
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b1010) begin
            failures++; $display("FAIL fwd_mem_priority got=%b exp=1010", {ForwardAE, ForwardBE});
        end
        RegWriteM = 0; #1;
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0101) begin
            failures++; $display("FAIL fwd_wb_when_mem_off got=%b exp=0101", {ForwardAE, ForwardBE});
        end
        clear_inputs();
        RsE = 0; RtE = 0; WriteRegM = 0; RegWriteM = 1; WriteRegW = 0; RegWriteW = 1; #1;
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            failures++; $display("FAIL fwd_reg0 got=%b exp=0000", {ForwardAE, ForwardBE});
        end
    endtask

    task automatic test_load_stall();
        clear_inputs();
        pulse_reset();
        RtE = 6; RsD = 6; RtD = 1; MemtoRegE = 1; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            failures++; $display("FAIL lwstall_rs got=%b exp=111", {StallF, StallD, FlushE});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (LoadStallCnt !== 16'd3) begin failures++; $display("FAIL lwstall_cnt got=%0d exp=3", LoadStallCnt); end
        reset = 1'b1; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            failures++; $display("FAIL stall_during_reset got=%b exp=111", {StallF, StallD, FlushE});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (LoadStallCnt !== 16'd0) begin failures++; $display("FAIL reset_over_incr got=%0d exp=0", LoadStallCnt); end
        RsD = 2; RtD = 6; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            failures++; $display("FAIL lwstall_rt got=%b exp=111", {StallF, StallD, FlushE});
        end
        MemtoRegE = 0; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            failures++; $display("FAIL nostall_noload got=%b exp=000", {StallF, StallD, FlushE});
        end
        @(posedge clk); #1;
        checks++;
        if (LoadStallCnt !== 16'd0) begin failures++; $display("FAIL cnt_hold got=%0d exp=0", LoadStallCnt); end
    endtask

    task automatic test_branch();
        clear_inputs();
        pulse_reset();
        RsD = 5; WriteRegM = 5; RegWriteM = 1; #1;
`ifdef HAZARD_BRANCH_RESOLVE_ID_EN
        checks++;
        if (ForwardAD !== 1'b1) begin failures++; $display("FAIL fwdAD got=%b exp=1", ForwardAD); end
        RsD = 0; RtD = 5; #1;
        checks++;
        if ({ForwardAD, ForwardBD} !== 2'b01) begin
            failures++; $display("FAIL fwdBD got=%b exp=01", {ForwardAD, ForwardBD});
        end
        RsD = 0; RtD = 0; WriteRegM = 0; #1;
        checks++;
        if ({ForwardAD, ForwardBD} !== 2'b00) begin
            failures++; $display("FAIL fwdD_reg0 got=%b exp=00", {ForwardAD, ForwardBD});
        end
        clear_inputs();
        BranchD = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5; RtD = 1; #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            failures++; $display("FAIL branchstall got=%b exp=111", {StallF, StallD, FlushE});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (BranchStallCnt !== 16'd3) begin failures++; $display("FAIL branch_cnt got=%0d exp=3", BranchStallCnt); end
        checks++;
        if (LoadStallCnt !== 16'd0) begin failures++; $display("FAIL branch_load_cnt got=%0d exp=0", LoadStallCnt); end
        MemtoRegE = 1; RtE = 5; @(posedge clk); #1;
        checks++;
        if ({LoadStallCnt, BranchStallCnt} !== {16'd1, 16'd4}) begin
            failures++; $display("FAIL both_stall_cnts got=%0d/%0d exp=1/4", LoadStallCnt, BranchStallCnt);
        end
        clear_inputs();
        BranchD = 1; MemtoRegM = 1; WriteRegM = 8; RtD = 8; #1;
        checks++;
        if (StallF !== 1'b1) begin failures++; $display("FAIL branch_mem_load got=%b exp=1", StallF); end
        BranchD = 0; #1;
        checks++;
        if (StallF !== 1'b0) begin failures++; $display("FAIL nobranch got=%b exp=0", StallF); end
        pulse_reset();
        checks++;
        if (BranchStallCnt !== 16'd0) begin failures++; $display("FAIL branch_cnt_reset got=%0d exp=0", BranchStallCnt); end
`else
        checks++;
        if ({ForwardAD, ForwardBD} !== 2'b00) begin
            failures++; $display("FAIL fwdD_disabled got=%b exp=00", {ForwardAD, ForwardBD});
        end
        clear_inputs();
        BranchD = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5; RtD = 1;
        MemtoRegM = 1; WriteRegM = 1; RegWriteM = 1; #1;
        checks++;
        if ({StallF, StallD, FlushE, ForwardAD, ForwardBD} !== 5'b0) begin
            failures++; $display("FAIL branch_disabled got=%b exp=00000", {StallF, StallD, FlushE, ForwardAD, ForwardBD});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (BranchStallCnt !== 16'd0) begin failures++; $display("FAIL branch_cnt_disabled got=%0d exp=0", BranchStallCnt); end
`endif
    endtask

    task automatic test_saturation();
        clear_inputs();
        pulse_reset();
        MemtoRegE = 1; RsD = 3; RtE = 3;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (LoadStallCnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", LoadStallCnt); end
        @(posedge clk); #1;
        checks++;
        if (LoadStallCnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", LoadStallCnt); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (LoadStallCnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", LoadStallCnt); end
        checks++;
        if (BranchStallCnt !== 16'd0) begin failures++; $display("FAIL sat_branch_idle got=%0d exp=0", BranchStallCnt); end
        pulse_reset();
        checks++;
        if (LoadStallCnt !== 16'd0) begin failures++; $display("FAIL sat_reset got=%h exp=0", LoadStallCnt); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_forward_e();
        test_load_stall();
        test_branch();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
